// File: rtl/spi_frame_receiver.sv
// SPI frame receiver: samples miso on synchronized sclk rises, frames the transfer with csN,
// and hands completed words to a one-entry output buffer. Optional SPI_FRAME_OVERRUN_CNT_EN adds overrunCnt.
module spi_frame_receiver #(
  parameter int DATA_WIDTH    = 16,
  parameter int CS_HOLD_EDGES = 1
) (
  input  logic                  clkIn,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  start,
  input  logic                  miso,
  output logic                  csN,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  input  logic                  dataReady,
  output logic                  overrun
`ifdef SPI_FRAME_OVERRUN_CNT_EN
  ,
  output logic [7:0]            overrunCnt
`endif
);

  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int HOLD_W = 2;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]            stateReg;
  logic [CNT_W-1:0]      bitCntReg;
  logic [HOLD_W-1:0]     holdCntReg;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic                  sclkMeta;
  logic                  sclkSync;
  logic                  sclkPrev;
  logic                  sclkRise;
  logic                  sclkFall;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      sclkMeta <= 1'b0;
      sclkSync <= 1'b0;
      sclkPrev <= 1'b0;
    end else begin
      sclkMeta <= sclk;
      sclkSync <= sclkMeta;
      sclkPrev <= sclkSync;
    end
  end

  assign sclkRise = sclkSync & ~sclkPrev;
  assign sclkFall = ~sclkSync & sclkPrev;

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      stateReg   <= IDLE;
      bitCntReg  <= '0;
      holdCntReg <= '0;
      shiftReg   <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) stateReg <= SETUP;
        end
        SETUP: begin
          bitCntReg  <= '0;
          holdCntReg <= '0;
          if (sclkFall) stateReg <= SHIFT;
        end
        SHIFT: begin
          if (sclkRise) begin
            shiftReg  <= {shiftReg[DATA_WIDTH-2:0], miso};
            bitCntReg <= bitCntReg + 1'b1;
            if (bitCntReg == CNT_W'(DATA_WIDTH - 1)) begin
              stateReg   <= HOLD;
              holdCntReg <= '0;
            end
          end
        end
        HOLD: begin
          if (sclkFall) begin
            if (holdCntReg == HOLD_W'(CS_HOLD_EDGES - 1)) stateReg <= DONE;
            else holdCntReg <= holdCntReg + 1'b1;
          end
        end
        DONE: begin
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // csN follows the state directly so it releases in the very cycle DONE is entered
  always_comb begin
    csN  = 1'b1;
    busy = (stateReg != IDLE);
    if (stateReg == SETUP || stateReg == SHIFT || stateReg == HOLD) csN = 1'b0;
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      dataOut   <= '0;
      dataValid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (stateReg == DONE) begin
        if (!dataValid || dataReady) begin
          dataOut   <= shiftReg;
          dataValid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dataReady) begin
        dataValid <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_OVERRUN_CNT_EN
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) overrunCnt <= '0;
    else if (overrun && overrunCnt != 8'hFF) overrunCnt <= overrunCnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver; covers SPI_FRAME_OVERRUN_CNT_EN when that macro is defined.
module tb_spi_frame_receiver;

  logic        clkIn = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        start = 1'b0;
  logic        miso = 1'b0;
  logic        dataReady = 1'b0;
  logic        csN;
  logic        busy;
  logic [15:0] dataOut;
  logic        dataValid;
  logic        overrun;
`ifdef SPI_FRAME_OVERRUN_CNT_EN
  logic [7:0]  overrunCnt;
`endif

  spi_frame_receiver #(.DATA_WIDTH(16), .CS_HOLD_EDGES(1)) dut (
    .clkIn(clkIn), .rst(rst), .sclk(sclk), .start(start), .miso(miso),
    .csN(csN), .busy(busy), .dataOut(dataOut), .dataValid(dataValid),
    .dataReady(dataReady), .overrun(overrun)
`ifdef SPI_FRAME_OVERRUN_CNT_EN
    , .overrunCnt(overrunCnt)
`endif
  );

  always #5 clkIn = ~clkIn;
  initial begin
    #2;
    forever #40 sclk = ~sclk;
  end

  int checks = 0;
  int fails = 0;
  int validCycles = 0;
  int ovPulses = 0;
  int framesOut = 0;
  int fallCnt = 0;
  logic vEdge = 1'b0;
  logic rEdge = 1'b0;
  logic [15:0] expQ[$];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  always @(posedge clkIn) begin
    vEdge <= dataValid;
    rEdge <= dataReady;
  end

  always @(negedge sclk) if (!csN) fallCnt++;

  // A newly loaded frame is visible when valid is high and the previous entry was empty or consumed
  always @(negedge clkIn) begin
    if (dataValid) validCycles++;
    if (overrun) ovPulses++;
    if (dataValid && (!vEdge || rEdge)) begin
      framesOut++;
      if (expQ.size() == 0) checkVal("unexpected_frame", 32'd1, 32'd0);
      else checkVal("frame", {16'h0, dataOut}, {16'h0, expQ.pop_front()});
    end
  end

  task automatic pulseStart();
    @(posedge clkIn); #1 start = 1'b1;
    @(posedge clkIn); #1 start = 1'b0;
  endtask

  task automatic runFrame(input logic [15:0] word, input bit expectOut, input bit midStart,
                          input bit readyInDone);
    int c;
    @(posedge sclk);
    pulseStart();
    if (expectOut) expQ.push_back(word);
    for (int i = 15; i >= 0; i--) begin
      @(negedge sclk); #1 miso = word[i];
      if (midStart && i == 8) pulseStart();
    end
    c = 0;
    while (busy && c < 400) begin
      @(posedge clkIn); #1;
      if (readyInDone && busy && csN) dataReady = 1'b1;
      c++;
    end
    if (busy) checkVal("frame_timeout", {31'h0, busy}, 32'd0);
    if (readyInDone) dataReady = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, ov0, f0;
    repeat (3) @(posedge clkIn);
    #1;
    checkVal("reset_csN", {31'h0, csN}, 32'd1);
    checkVal("reset_busy", {31'h0, busy}, 32'd0);
    checkVal("reset_valid", {31'h0, dataValid}, 32'd0);
    checkVal("reset_overrun", {31'h0, overrun}, 32'd0);
    checkVal("reset_dataOut", {16'h0, dataOut}, 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clkIn);
    #1;

    // Basic frame, consumer always ready
    dataReady = 1'b1;
    fallCnt = 0; validCycles = 0; ov0 = ovPulses;
    runFrame(16'hA5C3, 1'b1, 1'b0, 1'b0);
    checkVal("a5c3_falls_cs_low", fallCnt, 32'd17);
    checkVal("a5c3_valid_cycles", validCycles, 32'd1);
    checkVal("a5c3_dataOut", {16'h0, dataOut}, 32'hA5C3);
    checkVal("a5c3_no_overrun", ovPulses - ov0, 32'd0);

    // Consumer stalled: second frame is dropped
    dataReady = 1'b0;
    ov0 = ovPulses;
    runFrame(16'h1234, 1'b1, 1'b0, 1'b0);
    runFrame(16'hBEEF, 1'b0, 1'b0, 1'b0);
    checkVal("stall_dataOut", {16'h0, dataOut}, 32'h1234);
    checkVal("stall_valid", {31'h0, dataValid}, 32'd1);
    checkVal("stall_overrun_pulses", ovPulses - ov0, 32'd1);
`ifdef SPI_FRAME_OVERRUN_CNT_EN
    checkVal("stall_overrunCnt", {24'h0, overrunCnt}, 32'd1);
`endif
    dataReady = 1'b1;
    repeat (2) @(posedge clkIn);
    #1;
    checkVal("drain_valid", {31'h0, dataValid}, 32'd0);

    // Ready arriving exactly in the DONE cycle replaces a held frame without overrun
    dataReady = 1'b0;
    ov0 = ovPulses;
    runFrame(16'h5A5A, 1'b1, 1'b0, 1'b0);
    runFrame(16'h0F0F, 1'b1, 1'b0, 1'b1);
    checkVal("done_ready_dataOut", {16'h0, dataOut}, 32'h0F0F);
    checkVal("done_ready_valid", {31'h0, dataValid}, 32'd1);
    checkVal("done_ready_no_overrun", ovPulses - ov0, 32'd0);
    dataReady = 1'b1;
    repeat (2) @(posedge clkIn);

    // start while busy is ignored
    f0 = framesOut;
    runFrame(16'h3C96, 1'b1, 1'b1, 1'b0);
    repeat (40) @(posedge clkIn);
    #1;
    checkVal("busy_start_frames", framesOut - f0, 32'd1);
    checkVal("busy_start_idle", {31'h0, busy}, 32'd0);

    // Reset in the middle of a frame
    v0 = validCycles;
    @(posedge sclk);
    pulseStart();
    for (int i = 15; i >= 7; i--) begin
      @(negedge sclk); #1 miso = ~miso;
    end
    #23 rst = 1'b1;
    #1;
    checkVal("midrst_csN", {31'h0, csN}, 32'd1);
    checkVal("midrst_busy", {31'h0, busy}, 32'd0);
    checkVal("midrst_dataOut", {16'h0, dataOut}, 32'd0);
    repeat (3) @(posedge clkIn);
    #1 rst = 1'b0;
    repeat (300) @(posedge clkIn);
    #1;
    checkVal("postrst_busy", {31'h0, busy}, 32'd0);
    checkVal("postrst_csN", {31'h0, csN}, 32'd1);
    checkVal("postrst_no_valid", validCycles - v0, 32'd0);
    runFrame(16'hC001, 1'b1, 1'b0, 1'b0);
    checkVal("postrst_frame", {16'h0, dataOut}, 32'hC001);

`ifdef SPI_FRAME_OVERRUN_CNT_EN
    checkVal("cnt_after_reset", {24'h0, overrunCnt}, 32'd0);
    dataReady = 1'b0;
    ov0 = ovPulses;
    runFrame(16'h1111, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) runFrame(16'(k), 1'b0, 1'b0, 1'b0);
    checkVal("sat_pulses", ovPulses - ov0, 32'd300);
    checkVal("sat_overrunCnt", {24'h0, overrunCnt}, 32'd255);
    checkVal("sat_dataOut", {16'h0, dataOut}, 32'h1111);
    dataReady = 1'b1;
    repeat (2) @(posedge clkIn);
`endif

    repeat (4) @(posedge clkIn);
    #1;
    checkVal("scoreboard_empty", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
